// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - fixed-width SPI frame initiator, CS/SCLK/MOSI out, MISO captured into rx_data.
// Optional special-select line guarded by SPI_FRAME_MASTER_SPECIAL_EN.
module spi_frame_master #(
    parameter int MSB     = 16,
    parameter int CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tx_valid,
    output logic           tx_ready,
    input  logic [MSB-1:0] tx_data,
    output logic           rx_valid,
    output logic [MSB-1:0] rx_data,
    output logic           busy,
    output logic           spi_cs,
    output logic           spi_clk,
    output logic           spi_mosi,
    input  logic           spi_miso
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
    ,
    input  logic           tx_special,
    output logic           spi_special
`endif
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(MSB);
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(MSB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LOW,
        S_HIGH,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [MSB-2:0] tx_sh_q, tx_sh_d;
    logic [MSB-1:0] rx_sh_q, rx_sh_d;
    logic [MSB-1:0] rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           tx_ready_q, tx_ready_d;
    logic           busy_q, busy_d;
    logic           cs_q, cs_d;
    logic           sclk_q, sclk_d;
    logic           mosi_q, mosi_d;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
    logic           special_q, special_d;
`endif

    logic cnt_done;
    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
            special_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
            special_q  <= special_d;
`endif
        end
    end

    // Outputs are computed for the state being entered so they register on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        special_d  = special_q;
`endif
        if (!cnt_done) begin
            cnt_d = cnt_q - CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid && tx_ready_q) begin
                    state_d    = S_LEAD;
                    cnt_d      = DIV_LOAD;
                    bit_d      = BIT_LOAD;
                    tx_sh_d    = tx_data[MSB-2:0];
                    rx_sh_d    = '0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    cs_d       = 1'b0;
                    mosi_d     = tx_data[MSB-1];
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
                    special_d  = ~tx_special;
`endif
                end
            end
            S_LEAD: begin
                if (cnt_done) begin
                    state_d = S_LOW;
                    cnt_d   = DIV_LOAD;
                    sclk_d  = 1'b0;
                end
            end
            S_LOW: begin
                if (cnt_done) begin
                    state_d = S_HIGH;
                    cnt_d   = DIV_LOAD;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[MSB-2:0], spi_miso};
                    // The last bit stays on MOSI through TRAIL.
                    if (bit_q != '0) begin
                        mosi_d  = tx_sh_q[MSB-2];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
            end
            S_HIGH: begin
                if (cnt_done) begin
                    cnt_d = DIV_LOAD;
                    if (bit_q == '0) begin
                        state_d = S_TRAIL;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q - BW'(1);
                        sclk_d  = 1'b0;
                    end
                end
            end
            S_TRAIL: begin
                if (cnt_done) begin
                    state_d    = S_GAP;
                    cnt_d      = DIV_LOAD;
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
                    special_d  = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (cnt_done) begin
                    state_d    = S_IDLE;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign spi_cs   = cs_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
    assign spi_special = special_q;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - randomized self-checking bench for spi_frame_master against a frame-level slave model.
module tb_spi_frame_master;
    localparam int MSB = 16;
    localparam int DIV = 2;
    localparam int CS_LOW = (2 * MSB + 2) * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           tx_valid, tx_ready, rx_valid, busy, spi_cs, spi_clk, spi_mosi;
    logic           spi_miso = 1'b0;
    logic [MSB-1:0] tx_data, rx_data;
    logic           b_tx_valid, b_tx_ready, b_rx_valid, b_busy, b_cs, b_sclk, b_mosi;
    logic [MSB-1:0] b_tx_data, b_rx_data;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
    logic           tx_special, spi_special, b_tx_special, b_special;
`endif

    spi_frame_master #(.MSB(MSB), .CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .spi_cs(spi_cs), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        , .tx_special(tx_special), .spi_special(spi_special)
`endif
    );

    // Second instance at the fastest divider, MISO looped back from MOSI.
    spi_frame_master #(.MSB(MSB), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy), .spi_cs(b_cs), .spi_clk(b_sclk),
        .spi_mosi(b_mosi), .spi_miso(b_mosi)
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        , .tx_special(b_tx_special), .spi_special(b_special)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave model: samples MOSI on SCLK falls, shifts its word out MSB-first on SCLK rises.
    logic [MSB-1:0] q_slv[$];
    logic [MSB-1:0] q_rx[$];
    int             q_low[$];
    int             q_falls[$];
    int             cs_low_cnt = 0, fall_cnt = 0, cs_high_cnt = 0, last_gap = 0, slv_idx = 0;
    int             idle_edge_err = 0, rxv_pos_err = 0, sp_err = 0;
    logic           p_cs = 1'b1, p_sclk = 1'b1, cur_sp = 1'b0;
    logic [MSB-1:0] slv_rx = '0, slv_tx = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_cs = 1'b1; p_sclk = 1'b1; cs_low_cnt = 0; fall_cnt = 0; cs_high_cnt = 0;
        end else begin
            if (spi_clk != p_sclk && (spi_cs || p_cs)) idle_edge_err++;
            if (p_cs && !spi_cs) begin
                last_gap = cs_high_cnt; cs_low_cnt = 0; fall_cnt = 0; slv_idx = 0;
                slv_rx = '0; spi_miso = slv_tx[MSB-1];
            end
            if (!spi_cs) begin
                cs_low_cnt++;
                if (p_sclk && !spi_clk) begin
                    fall_cnt++;
                    slv_rx = {slv_rx[MSB-2:0], spi_mosi};
                end
                if (!p_sclk && spi_clk) begin
                    slv_idx++;
                    if (slv_idx < MSB) spi_miso = slv_tx[MSB-1-slv_idx];
                end
            end
            if (!p_cs && spi_cs) begin
                q_slv.push_back(slv_rx); q_low.push_back(cs_low_cnt); q_falls.push_back(fall_cnt);
                cs_high_cnt = 0;
            end
            if (spi_cs) cs_high_cnt++;
            if (rx_valid) begin
                q_rx.push_back(rx_data);
                if (!(spi_cs && !p_cs)) rxv_pos_err++;
            end
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
            if (spi_special !== (spi_cs | ~cur_sp)) sp_err++;
`endif
            p_cs = spi_cs; p_sclk = spi_clk;
        end
    end

    int             b_low = 0, b_falls = 0, b_sp_err = 0;
    logic           bp_sclk = 1'b1;
    logic [MSB-1:0] b_slv = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!b_cs) begin
                b_low++;
                if (bp_sclk && !b_sclk) begin
                    b_falls++;
                    b_slv = {b_slv[MSB-2:0], b_mosi};
                end
            end
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
            if (b_special !== b_cs) b_sp_err++;
`endif
            bp_sclk = b_sclk;
        end
    end

    task automatic q_clear();
        q_slv.delete(); q_rx.delete(); q_low.delete(); q_falls.delete();
    endtask

    task automatic send_frame(input logic [MSB-1:0] tx, input logic [MSB-1:0] slv, input logic sp);
        int t = 0;
        slv_tx = slv;
        cur_sp = sp;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        tx_special = sp;
`endif
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        tx_data  = tx;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int t = 0;
        while (q_low.size() < n && t < 3000) begin @(negedge clk); t++; end
        check_eq(tag, 32'(q_low.size() >= n), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int i, input logic [MSB-1:0] tx, input logic [MSB-1:0] slv);
        check_eq({tag, " mosi_word"}, (i < q_slv.size()) ? 32'(q_slv[i]) : 32'hDEAD0000, 32'(tx));
        check_eq({tag, " rx_data"}, (i < q_rx.size()) ? 32'(q_rx[i]) : 32'hDEAD0000, 32'(slv));
        check_eq({tag, " cs_low_cycles"}, (i < q_low.size()) ? 32'(q_low[i]) : 32'hDEAD0000, 32'(CS_LOW));
        check_eq({tag, " sclk_falls"}, (i < q_falls.size()) ? 32'(q_falls[i]) : 32'hDEAD0000, 32'(MSB));
    endtask

    logic [MSB-1:0] exp_tx[6];
    logic [MSB-1:0] exp_slv[6];

    initial begin
        int t;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; b_tx_valid = 1'b0; b_tx_data = '0;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        tx_special = 1'b0; b_tx_special = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset cs", 32'(spi_cs), 32'd1);
        check_eq("reset sclk", 32'(spi_clk), 32'd1);
        check_eq("reset mosi", 32'(spi_mosi), 32'd0);
        check_eq("reset ready", 32'(tx_ready), 32'd1);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset rx_valid", 32'(rx_valid), 32'd0);
        check_eq("reset rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        q_clear();
        send_frame(16'h0705, 16'h0000, 1'b0);
        #20 check_eq("busy during frame", 32'(busy), 32'd1);
        wait_frames(1, "t1 frame done");
        check_frame("t1", 0, 16'h0705, 16'h0000);
        check_eq("t1 rx pulses", 32'(q_rx.size()), 32'd1);

        q_clear();
        send_frame(16'h0800, 16'hA5C3, 1'b0);
        wait_frames(1, "t2 frame done");
        check_frame("t2", 0, 16'h0800, 16'hA5C3);
        check_eq("t2 rx pulses", 32'(q_rx.size()), 32'd1);

        q_clear();
        slv_tx = 16'h3C5A; cur_sp = 1'b0;
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        tx_special = 1'b0;
`endif
        tx_data = 16'h0901; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 16'h0903;
        t = 0;
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_frames(2, "b2b frames done");
        check_frame("b2b0", 0, 16'h0901, 16'h3C5A);
        check_frame("b2b1", 1, 16'h0903, 16'h3C5A);
        check_eq("b2b cs gap>=DIV+1", 32'(last_gap >= DIV + 1), 32'd1);
        repeat (100) @(negedge clk);
        check_eq("b2b frame count", 32'(q_low.size()), 32'd2);

        q_clear();
        send_frame(16'h1357, 16'h0F0F, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("ignore ready low", 32'(tx_ready), 32'd0);
        tx_data = 16'hFFFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frames(1, "ignore frame done");
        repeat (150) @(negedge clk);
        check_frame("ignore", 0, 16'h1357, 16'h0F0F);
        check_eq("ignore frame count", 32'(q_low.size()), 32'd1);

        q_clear();
        send_frame(16'hC3A5, 16'h5A5A, 1'b1);
        t = 0;
        while (fall_cnt < 5 && t < 500) begin @(negedge clk); t++; end
        check_eq("rst reached 5th fall", 32'(fall_cnt >= 5), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst async cs", 32'(spi_cs), 32'd1);
        check_eq("rst async sclk", 32'(spi_clk), 32'd1);
        check_eq("rst async mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst async rx_data", 32'(rx_data), 32'd0);
        check_eq("rst async ready", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("rst no rx_valid", 32'(q_rx.size()), 32'd0);
        check_eq("rst rx_data kept 0", 32'(rx_data), 32'd0);
        send_frame(16'h0705, 16'h1E2D, 1'b0);
        wait_frames(1, "post-rst frame done");
        check_frame("post-rst", 0, 16'h0705, 16'h1E2D);

        q_clear();
        for (int i = 0; i < 6; i++) begin
            exp_tx[i]  = 16'($urandom);
            exp_slv[i] = 16'($urandom);
            send_frame(exp_tx[i], exp_slv[i], 1'($urandom_range(0, 1)));
            wait_frames(i + 1, "rand frame done");
        end
        for (int i = 0; i < 6; i++) check_frame("rand", i, exp_tx[i], exp_slv[i]);

        b_low = 0; b_falls = 0; b_slv = '0;
        b_tx_data = 16'h8001; b_tx_valid = 1'b1;
        @(posedge clk);
        #1 b_tx_valid = 1'b0;
        t = 0;
        while (!b_rx_valid && t < 500) begin @(negedge clk); t++; end
        check_eq("div1 rx_valid seen", 32'(t < 500), 32'd1);
        repeat (4) @(negedge clk);
        check_eq("div1 cs_low_cycles", 32'(b_low), 32'd34);
        check_eq("div1 sclk_falls", 32'(b_falls), 32'(MSB));
        check_eq("div1 mosi_word", 32'(b_slv), 32'h8001);
        check_eq("div1 rx_data", 32'(b_rx_data), 32'h8001);

        check_eq("sclk edges with cs high", 32'(idle_edge_err), 32'd0);
        check_eq("rx_valid placement", 32'(rxv_pos_err), 32'd0);
`ifdef SPI_FRAME_MASTER_SPECIAL_EN
        check_eq("special tracks cs", 32'(sp_err), 32'd0);
        check_eq("div1 special tracks cs", 32'(b_sp_err), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
